// File: rtl/dla_pkg.sv
// Shared definitions for the DLA pixel arbiter: FSM encoding, lane
// indices, default geometry/colour and the round-robin pointer helper.
package dla_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GRANT = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    localparam int NUM_LANES   = 3;
    localparam int LANE_WALKER = 0;
    localparam int LANE_AGG    = 1;
    localparam int LANE_HOST   = 2;

    localparam int          DEF_ADDR_W   = 19;
    localparam int          DEF_COLOR_W  = 16;
    localparam int          DEF_NUM_PIX  = 307200;
    localparam logic [15:0] DEF_BG_COLOR = 16'h0000;

    // Pointer value after serving the given one-hot lane: the lane that
    // follows it in the cyclic order walker -> agg -> host -> walker.
    function automatic logic [1:0] rr_next_ptr(input logic [NUM_LANES-1:0] sel);
        if (sel[LANE_WALKER]) return 2'(LANE_AGG);
        if (sel[LANE_AGG])    return 2'(LANE_HOST);
        return 2'(LANE_WALKER);
    endfunction

endpackage

// File: rtl/dla_rr_select.sv
// Combinational 3-lane round-robin picker: selects the first requesting
// lane at or after the pointer, wrapping 0 -> 1 -> 2 -> 0.
module dla_rr_select
    import dla_pkg::*;
(
    input  logic [NUM_LANES-1:0] i_req,
    input  logic [1:0]           i_ptr,
    output logic [NUM_LANES-1:0] o_sel,
    output logic                 o_valid
);

    logic [1:0] w_first;
    logic [1:0] w_second;
    logic [1:0] w_third;

    // Rotate the search order to start at the pointer, then take the first hit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the block can leave it unassigned (latch).
        o_sel    = '0;
        o_valid  = |i_req;
        w_first  = 2'(LANE_WALKER);
        w_second = 2'(LANE_AGG);
        w_third  = 2'(LANE_HOST);
        case (i_ptr)
            2'(LANE_AGG): begin
                w_first  = 2'(LANE_AGG);
                w_second = 2'(LANE_HOST);
                w_third  = 2'(LANE_WALKER);
            end
            2'(LANE_HOST): begin
                w_first  = 2'(LANE_HOST);
                w_second = 2'(LANE_WALKER);
                w_third  = 2'(LANE_AGG);
            end
            default: ;
        endcase
        if (i_req[w_first])       o_sel[w_first]  = 1'b1;
        else if (i_req[w_second]) o_sel[w_second] = 1'b1;
        else if (i_req[w_third])  o_sel[w_third]  = 1'b1;
    end

endmodule

// File: rtl/dla_pixel_arbiter.sv
// Framebuffer write-port arbiter for the DLA pixel sources. Three lanes
// share one stall-aware write port in round-robin order; a built-in clear
// sweep fills the screen with BG_COLOR and outranks every lane.
module dla_pixel_arbiter
    import dla_pkg::*;
#(
    parameter int                 ADDR_W   = DEF_ADDR_W,
    parameter int                 COLOR_W  = DEF_COLOR_W,
    parameter int                 NUM_PIX  = DEF_NUM_PIX,
    parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(DEF_BG_COLOR)
) (
    input  logic                         iCLK,
    input  logic                         iRST_N,
    input  logic [NUM_LANES-1:0]         iReq,
    input  logic [NUM_LANES*ADDR_W-1:0]  iAddr,
    input  logic [NUM_LANES*COLOR_W-1:0] iColor,
    output logic [NUM_LANES-1:0]         oGrant,
    input  logic                         iClear,
    output logic                         oWr_En,
    output logic [ADDR_W-1:0]            oAddr,
    output logic [COLOR_W-1:0]           oData,
    input  logic                         iWr_Ready,
    output logic                         oBusy,
    output logic                         oClear_Done
);

    // The sweep counter stops here, so it never runs past the visible pixels.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

    state_t                 r_state,         w_state_nxt;
    logic [1:0]             r_ptr,           w_ptr_nxt;
    logic                   r_clear_pending, w_clear_pending_nxt;
    logic [NUM_LANES-1:0]   r_sel,           w_sel_nxt;
    logic                   r_wr_en,         w_wr_en_nxt;
    logic [ADDR_W-1:0]      r_addr,          w_addr_nxt;
    logic [COLOR_W-1:0]     r_data,          w_data_nxt;
    logic [NUM_LANES-1:0]   r_grant,         w_grant_nxt;
    logic                   r_clear_done,    w_clear_done_nxt;

    logic [NUM_LANES-1:0]   w_pick;
    logic                   w_pick_valid;
    logic [ADDR_W-1:0]      w_lane_addr;
    logic [COLOR_W-1:0]     w_lane_color;

    dla_rr_select u_rr_select (
        .i_req   (iReq),
        .i_ptr   (r_ptr),
        .o_sel   (w_pick),
        .o_valid (w_pick_valid)
    );

    // Route the picked lane's address and colour towards the write latch.
    always_comb begin
        w_lane_addr  = '0;
        w_lane_color = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_pick[i]) begin
                w_lane_addr  = iAddr[i*ADDR_W +: ADDR_W];
                w_lane_color = iColor[i*COLOR_W +: COLOR_W];
            end
        end
    end

    // Next-state and next-output logic; each register holds unless changed.
    always_comb begin
        w_state_nxt         = r_state;
        w_ptr_nxt           = r_ptr;
        w_sel_nxt           = r_sel;
        w_wr_en_nxt         = r_wr_en;
        w_addr_nxt          = r_addr;
        w_data_nxt          = r_data;
        w_grant_nxt         = '0;
        w_clear_done_nxt    = 1'b0;
        // A clear request is remembered in every state except the sweep itself.
        w_clear_pending_nxt = r_clear_pending | (iClear && (r_state != ST_CLEAR));

        case (r_state)
            ST_IDLE: begin
                // Clear wins over lane requests, including one arriving this cycle.
                if (r_clear_pending || iClear) begin
                    w_state_nxt         = ST_CLEAR;
                    w_clear_pending_nxt = 1'b0;
                    w_wr_en_nxt         = 1'b1;
                    w_addr_nxt          = '0;
                    w_data_nxt          = BG_COLOR;
                end else if (w_pick_valid) begin
                    w_state_nxt = ST_WRITE;
                    w_sel_nxt   = w_pick;
                    w_wr_en_nxt = 1'b1;
                    w_addr_nxt  = w_lane_addr;
                    w_data_nxt  = w_lane_color;
                end
            end

            ST_WRITE: begin
                // Address and data stay latched for as long as the port stalls.
                if (iWr_Ready) begin
                    w_state_nxt = ST_GRANT;
                    w_wr_en_nxt = 1'b0;
                    w_grant_nxt = r_sel;
                    w_ptr_nxt   = rr_next_ptr(r_sel);
                end
            end

            ST_GRANT: begin
                // Requests are ignored here so a lane still holding iReq
                // while it sees its grant is not served twice.
                w_state_nxt = ST_IDLE;
            end

            ST_CLEAR: begin
                if (iWr_Ready) begin
                    if (r_addr == LAST_ADDR) begin
                        w_state_nxt      = ST_IDLE;
                        w_wr_en_nxt      = 1'b0;
                        w_addr_nxt       = '0;
                        w_clear_done_nxt = 1'b1;
                    end else begin
                        w_addr_nxt = r_addr + ADDR_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_wr_en_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any write or sweep silently.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state         <= ST_IDLE;
            r_ptr           <= 2'(LANE_WALKER);
            r_clear_pending <= 1'b0;
            r_sel           <= '0;
            r_wr_en         <= 1'b0;
            r_addr          <= '0;
            r_data          <= '0;
            r_grant         <= '0;
            r_clear_done    <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            r_state         <= w_state_nxt;
            r_ptr           <= w_ptr_nxt;
            r_clear_pending <= w_clear_pending_nxt;
            r_sel           <= w_sel_nxt;
            r_wr_en         <= w_wr_en_nxt;
            r_addr          <= w_addr_nxt;
            r_data          <= w_data_nxt;
            r_grant         <= w_grant_nxt;
            r_clear_done    <= w_clear_done_nxt;
        end
    end

    assign oGrant      = r_grant;
    assign oWr_En      = r_wr_en;
    assign oAddr       = r_addr;
    assign oData       = r_data;
    assign oClear_Done = r_clear_done;
    assign oBusy       = r_clear_pending | (r_state == ST_CLEAR);

endmodule

// File: tb/tb_dla_pixel_arbiter.sv
// Self-checking bench for dla_pixel_arbiter: directed scenarios plus a
// randomized round-robin run checked against a lane-order reference model.
module tb_dla_pixel_arbiter;

    localparam int          AW   = 19;
    localparam int          CW   = 16;
    localparam int          NPIX = 16;
    localparam logic [15:0] BG   = 16'h5A5A;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      req = '0;
    logic [3*AW-1:0] addr_bus = '0;
    logic [3*CW-1:0] color_bus = '0;
    logic            clear = 1'b0;
    logic            ready = 1'b1;
    logic [2:0]      grant;
    logic            wr_en;
    logic [AW-1:0]   o_addr;
    logic [CW-1:0]   o_data;
    logic            busy;
    logic            done;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    logic [AW-1:0]    lane_addr  [3];
    logic [CW-1:0]    lane_color [3];
    logic [AW+CW-1:0] acc_q [$];

    dla_pixel_arbiter #(
        .ADDR_W   (AW),
        .COLOR_W  (CW),
        .NUM_PIX  (NPIX),
        .BG_COLOR (BG)
    ) dut (
        .iCLK        (clk),
        .iRST_N      (rst_n),
        .iReq        (req),
        .iAddr       (addr_bus),
        .iColor      (color_bus),
        .oGrant      (grant),
        .iClear      (clear),
        .oWr_En      (wr_en),
        .oAddr       (o_addr),
        .oData       (o_data),
        .iWr_Ready   (ready),
        .oBusy       (busy),
        .oClear_Done (done)
    );

    always #5 clk = ~clk;

    // Framebuffer side: every write accepted on a posedge is logged.
    always @(posedge clk) begin
        if (rst_n && wr_en && ready) acc_q.push_back({o_addr, o_data});
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference rule: first requesting lane at or after the pointer, cyclic.
    function automatic int rr_expect(input logic [2:0] set, input int ptr);
        for (int k = 0; k < 3; k++) begin
            if (set[(ptr + k) % 3]) return (ptr + k) % 3;
        end
        return -1;
    endfunction

    task automatic set_lane_val(input int l, input logic [AW-1:0] a, input logic [CW-1:0] c);
        lane_addr[l]              = a;
        lane_color[l]             = c;
        addr_bus[l*AW +: AW]      = a;
        color_bus[l*CW +: CW]     = c;
    endtask

    task automatic set_lane(input int l);
        set_lane_val(l, AW'($urandom), CW'($urandom));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; clear = 1'b0; ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        acc_q.delete();
        done_cnt = 0;
    endtask

    task automatic wait_grant(output logic [2:0] g, output bit timed_out, input bit rand_ready);
        g = '0;
        timed_out = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (grant != 3'b000) begin
                g = grant;
                timed_out = 1'b0;
                break;
            end
            if (rand_ready) ready = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; req = 3'b111; clear = 1'b1; ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({grant, wr_en, busy, done} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_flags got grant=%b wr_en=%b busy=%b done=%b exp all 0", grant, wr_en, busy, done);
        end
        n_checks++;
        if ({o_addr, o_data} !== '0) begin
            n_errors++;
            $display("FAIL reset_data got addr=%h data=%h exp 0/0", o_addr, o_data);
        end
        req = '0; clear = 1'b0;
    endtask

    task automatic test_single_lane();
        do_reset();
        set_lane_val(0, 19'h00123, 16'hF000);
        ready = 1'b1;
        req = 3'b001;
        @(negedge clk);
        n_checks++;
        if ({wr_en, o_addr, o_data, grant} !== {1'b1, 19'h00123, 16'hF000, 3'b000}) begin
            n_errors++;
            $display("FAIL single_write got wr_en=%b addr=%h data=%h grant=%b exp 1/00123/f000/000", wr_en, o_addr, o_data, grant);
        end
        @(negedge clk);
        n_checks++;
        if ({grant, wr_en} !== {3'b001, 1'b0}) begin
            n_errors++;
            $display("FAIL single_grant got grant=%b wr_en=%b exp 001/0", grant, wr_en);
        end
        req = '0;
        @(negedge clk);
        n_checks++;
        if (grant !== 3'b000) begin
            n_errors++;
            $display("FAIL single_grant_pulse got grant=%b exp 000", grant);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (acc_q.size() != 1 || acc_q[0] !== {19'h00123, 16'hF000} || wr_en !== 1'b0) begin
            n_errors++;
            $display("FAIL single_no_second got writes=%0d wr_en=%b exp 1 write, wr_en=0", acc_q.size(), wr_en);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] g;
        logic [2:0] exp_g;
        bit         to;
        int         l;
        do_reset();
        for (int i = 0; i < 3; i++) set_lane(i);
        ready = 1'b1;
        req = 3'b111;
        for (int n = 0; n < 4; n++) begin
            wait_grant(g, to, 1'b0);
            l = n % 3;
            exp_g = 3'b001 << l;
            n_checks++;
            if (to || g !== exp_g) begin
                n_errors++;
                $display("FAIL rr_order n=%0d got=%b exp=%b timeout=%0d", n, g, exp_g, to);
            end
            n_checks++;
            if (acc_q.size() != 1 || acc_q[0] !== {lane_addr[l], lane_color[l]}) begin
                n_errors++;
                $display("FAIL rr_data n=%0d writes=%0d exp {%h,%h}", n, acc_q.size(), lane_addr[l], lane_color[l]);
            end
            acc_q.delete();
            req[l] = 1'b0;
            @(negedge clk);
            set_lane(l);
            req[l] = 1'b1;
        end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_stall();
        logic [AW+CW:0] exp_w;
        do_reset();
        set_lane(1);
        ready = 1'b0;
        req = 3'b010;
        @(negedge clk);
        exp_w = {1'b1, lane_addr[1], lane_color[1]};
        n_checks++;
        if ({wr_en, o_addr, o_data} !== exp_w) begin
            n_errors++;
            $display("FAIL stall_start got %h exp %h", {wr_en, o_addr, o_data}, exp_w);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if ({wr_en, o_addr, o_data} !== exp_w || grant !== 3'b000) begin
                n_errors++;
                $display("FAIL stall_hold k=%0d got %h grant=%b exp %h grant=000", k, {wr_en, o_addr, o_data}, grant, exp_w);
            end
        end
        ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({grant, wr_en} !== {3'b010, 1'b0} || acc_q.size() != 1) begin
            n_errors++;
            $display("FAIL stall_grant got grant=%b wr_en=%b writes=%0d exp 010/0/1", grant, wr_en, acc_q.size());
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_sweep_done(input string tag, input bit rand_ready);
        bit seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            n_checks++;
            if (busy !== 1'b1 || grant !== 3'b000) begin
                n_errors++;
                $display("FAIL %s_busy cycle=%0d got busy=%b grant=%b exp 1/000", tag, c, busy, grant);
            end
            if (rand_ready) ready = ($urandom_range(0, 2) != 0);
        end
        n_checks++;
        if (!seen || {wr_en, o_addr, busy} !== {1'b0, 19'h0, 1'b0}) begin
            n_errors++;
            $display("FAIL %s_done seen=%0d got wr_en=%b addr=%h busy=%b exp 0/0/0", tag, seen, wr_en, o_addr, busy);
        end
        ready = 1'b1;
    endtask

    task automatic check_sweep_log(input string tag, input int skip);
        int bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (skip + i >= acc_q.size() || acc_q[skip + i] !== {AW'(i), BG}) bad++;
        end
        n_checks++;
        if (acc_q.size() != skip + NPIX || bad != 0) begin
            n_errors++;
            $display("FAIL %s_sweep got writes=%0d bad=%0d exp writes=%0d bad=0", tag, acc_q.size(), bad, skip + NPIX);
        end
    endtask

    task automatic test_clear_vs_req();
        logic [2:0] g;
        bit         to;
        do_reset();
        set_lane(1);
        ready = 1'b1;
        req = 3'b010;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++;
        if ({busy, wr_en, o_addr, o_data, grant} !== {1'b1, 1'b1, 19'h0, BG, 3'b000}) begin
            n_errors++;
            $display("FAIL clr_first got busy=%b wr_en=%b addr=%h data=%h grant=%b exp 1/1/0/%h/000", busy, wr_en, o_addr, o_data, grant, BG);
        end
        wait_sweep_done("clr", 1'b1);
        check_sweep_log("clr", 0);
        acc_q.delete();
        wait_grant(g, to, 1'b1);
        n_checks++;
        if (to || g !== 3'b010 || acc_q.size() != 1 || acc_q[0] !== {lane_addr[1], lane_color[1]}) begin
            n_errors++;
            $display("FAIL clr_then_lane1 got grant=%b timeout=%0d writes=%0d exp 010/0/1", g, to, acc_q.size());
        end
        req = '0;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt != 1) begin
            n_errors++;
            $display("FAIL clr_done_count got=%0d exp=1", done_cnt);
        end
    endtask

    task automatic test_clear_mid_write();
        logic [2:0] g;
        bit         to;
        do_reset();
        set_lane(2);
        ready = 1'b0;
        req = 3'b100;
        @(negedge clk);
        n_checks++;
        if ({wr_en, o_addr} !== {1'b1, lane_addr[2]} || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_write got wr_en=%b addr=%h busy=%b exp 1/%h/0", wr_en, o_addr, busy, lane_addr[2]);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        ready = 1'b1;
        n_checks++;
        if (busy !== 1'b1 || wr_en !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_busy got busy=%b wr_en=%b exp 1/1", busy, wr_en);
        end
        wait_grant(g, to, 1'b0);
        n_checks++;
        if (to || g !== 3'b100 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_grant got grant=%b busy=%b timeout=%0d exp 100/1/0", g, busy, to);
        end
        req = '0;
        wait_sweep_done("mid", 1'b0);
        n_checks++;
        if (acc_q.size() < 1 || acc_q[0] !== {lane_addr[2], lane_color[2]}) begin
            n_errors++;
            $display("FAIL mid_first_write writes=%0d exp lane2 {%h,%h} first", acc_q.size(), lane_addr[2], lane_color[2]);
        end
        check_sweep_log("mid", 1);
        repeat (2) @(negedge clk);
        n_checks++;
        if (done_cnt != 1) begin
            n_errors++;
            $display("FAIL mid_done_count got=%0d exp=1", done_cnt);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [2:0] g;
        bit         to;
        bit         hit = 1'b0;
        do_reset();
        set_lane(0);
        ready = 1'b1;
        req = 3'b001;
        wait_grant(g, to, 1'b0);
        req = '0;
        n_checks++;
        if (to || g !== 3'b001) begin
            n_errors++;
            $display("FAIL rst_pre_grant got=%b timeout=%0d exp 001", g, to);
        end
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (wr_en && o_addr == 19'd7) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!hit) begin
            n_errors++;
            $display("FAIL rst_reach_addr7 got addr=%h wr_en=%b exp addr 7 reached", o_addr, wr_en);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({grant, wr_en, o_addr, o_data, busy, done} !== '0) begin
            n_errors++;
            $display("FAIL rst_immediate got grant=%b wr_en=%b addr=%h data=%h busy=%b done=%b exp all 0", grant, wr_en, o_addr, o_data, busy, done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) set_lane(i);
        req = 3'b111;
        @(negedge clk);
        n_checks++;
        if ({wr_en, o_addr, o_data} !== {1'b1, lane_addr[0], lane_color[0]}) begin
            n_errors++;
            $display("FAIL rst_ptr0_write got wr_en=%b addr=%h exp 1/%h", wr_en, o_addr, lane_addr[0]);
        end
        wait_grant(g, to, 1'b0);
        req = '0;
        n_checks++;
        if (to || g !== 3'b001 || done_cnt != 0) begin
            n_errors++;
            $display("FAIL rst_after got grant=%b done_cnt=%0d timeout=%0d exp 001/0/0", g, done_cnt, to);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [2:0] g;
        logic [2:0] exp_g;
        logic [2:0] add;
        bit         to;
        int         ptr_m = 0;
        int         l;
        do_reset();
        req = 3'($urandom_range(1, 7));
        for (int i = 0; i < 3; i++) if (req[i]) set_lane(i);
        for (int n = 0; n < 30; n++) begin
            wait_grant(g, to, 1'b1);
            l = rr_expect(req, ptr_m);
            exp_g = 3'b001 << l;
            n_checks++;
            if (to || g !== exp_g) begin
                n_errors++;
                $display("FAIL rand_grant n=%0d got=%b exp=%b req=%b timeout=%0d", n, g, exp_g, req, to);
                break;
            end
            n_checks++;
            if (acc_q.size() != 1 || acc_q[0] !== {lane_addr[l], lane_color[l]}) begin
                n_errors++;
                $display("FAIL rand_data n=%0d writes=%0d exp {%h,%h}", n, acc_q.size(), lane_addr[l], lane_color[l]);
            end
            acc_q.delete();
            ptr_m = (l + 1) % 3;
            req = req & ~exp_g;
            add = 3'($urandom) & ~exp_g & ~req;
            if ((req | add) == 3'b000) add = (3'b001 << ((l + $urandom_range(1, 2)) % 3));
            for (int i = 0; i < 3; i++) if (add[i]) set_lane(i);
            req = req | add;
        end
        req = '0;
        ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_round_robin();
        test_stall();
        test_clear_vs_req();
        test_clear_mid_write();
        test_reset_mid_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
